// File: rtl/rssb_pkg.sv
// Shared types and helper constants for the RSSB (reverse subtract, skip if borrow) CPU.
package rssb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_READ,
      S_EXEC,
      S_HALT
   } state_t;

   localparam int DEF_BW = 8;
   localparam int DEF_AW = 4;

   // Operand value that stops the machine (top address of the memory).
   function automatic int halt_opnd(input int aw);
      return (1 << aw) - 1;
   endfunction

   // Default memory-mapped output location, just below the halt operand.
   function automatic int out_addr_dflt(input int aw);
      return (1 << aw) - 2;
   endfunction

endpackage

// File: rtl/rssb_mem.sv
// Unified program/data memory: one synchronous write port, one combinational read port.
module rssb_mem #(
   parameter int BW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [BW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [BW-1:0] rdata
);

   logic [BW-1:0] mem [0:(1<<AW)-1];

   // Contents survive reset; only the caller's write enable gates updates.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rssb_cpu_nb.sv
// Single-instruction RSSB CPU: FETCH/READ/EXEC per instruction, memory-mapped output.
// Define RSSB_CYCCNT_EN to add the saturating executed-instruction counter instr_cnt.
module rssb_cpu_nb
   import rssb_pkg::*;
#(
   parameter int BW       = DEF_BW,
   parameter int AW       = DEF_AW,
   parameter int OUT_ADDR = out_addr_dflt(AW)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [BW-1:0] load_data,
   input  logic          start,
   output logic          busy,
   output logic          halted,
   output logic          out_valid,
   output logic [BW-1:0] out_data
`ifdef RSSB_CYCCNT_EN
   ,
   output logic [15:0]   instr_cnt
`endif
);

   localparam logic [AW-1:0] HALT_OP = AW'(halt_opnd(AW));
   localparam logic [AW-1:0] OUT_A   = AW'(OUT_ADDR);

   state_t        state, state_nxt;
   logic [AW-1:0] pc, opnd, raddr, waddr;
   logic [BW-1:0] acc, opr, rdata, wdata;
   logic [BW:0]   diff;
   logic          borrow, we, exec_we, load_ok, start_ok;

   assign start_ok = start && !load_en && (state == S_IDLE || state == S_HALT);
   assign load_ok  = load_en && !busy;
   assign diff     = {1'b0, opr} - {1'b0, acc};
   assign borrow   = diff[BW];

   // Reset forces IDLE asynchronously, which also kills any pending EXEC write.
   assign exec_we = (state == S_EXEC);
   assign we      = load_ok || exec_we;
   assign waddr   = exec_we ? opnd : load_addr;
   assign wdata   = exec_we ? diff[BW-1:0] : load_data;
   assign raddr   = (state == S_FETCH) ? pc : opnd;

   rssb_mem #(.BW(BW), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_HALT: if (start_ok) state_nxt = S_FETCH;
         S_FETCH:        state_nxt = (rdata[AW-1:0] == HALT_OP) ? S_HALT : S_READ;
         S_READ:         state_nxt = S_EXEC;
         S_EXEC:         state_nxt = S_FETCH;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state == S_FETCH) || (state == S_READ) || (state == S_EXEC);
      halted = (state == S_HALT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc        <= '0;
         acc       <= '0;
         opnd      <= '0;
         opr       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            S_IDLE, S_HALT: begin
               if (start_ok) begin
                  pc  <= '0;
                  acc <= '0;
               end
            end
            S_FETCH: opnd <= rdata[AW-1:0];
            S_READ:  opr  <= rdata;
            S_EXEC: begin
               acc <= diff[BW-1:0];
               pc  <= borrow ? pc + AW'(2) : pc + AW'(1);
               if (opnd == OUT_A) begin
                  out_valid <= 1'b1;
                  out_data  <= diff[BW-1:0];
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RSSB_CYCCNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                 instr_cnt <= '0;
      else if (start_ok)                        instr_cnt <= '0;
      else if (exec_we && instr_cnt != 16'hFFFF) instr_cnt <= instr_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_rssb_cpu_nb.sv
// Directed bench for rssb_cpu_nb (BW=8, AW=4) with hand-computed expectations.
module tb_rssb_cpu_nb;
   import rssb_pkg::*;

   logic       clk = 1'b0;
   logic       rst, load_en, start;
   logic [3:0] load_addr;
   logic [7:0] load_data;
   logic       busy, halted, out_valid;
   logic [7:0] out_data;
`ifdef RSSB_CYCCNT_EN
   logic [15:0] instr_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int ov_cnt = 0;
   int ov_base;

   rssb_cpu_nb #(.BW(8), .AW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .start     (start),
      .busy      (busy),
      .halted    (halted),
      .out_valid (out_valid),
      .out_data  (out_data)
`ifdef RSSB_CYCCNT_EN
      ,
      .instr_cnt (instr_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (out_valid === 1'b1) ov_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input int d);
      load_en   = 1'b1;
      load_addr = 4'(a);
      load_data = 8'(d);
      tick();
      load_en   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_halt(input string tag, input int max);
      int i = 0;
      while (halted !== 1'b1 && i < max) begin
         tick();
         i++;
      end
      check(tag, 32'(halted), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; load_en = 1'b0; start = 1'b0; load_addr = '0; load_data = '0;
      tick(); tick();
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_halted",    32'(halted),    32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      rst = 1'b1;
      tick();
      for (int a = 0; a < 16; a++) load(a, 0);

      // No-borrow step then halt, exact timing.
      load(0, 5); load(1, 15); load(5, 7);
      pulse_start();
      tick(); tick(); tick();
      check("a_halt_early", 32'(halted), 32'd0);
      tick();
      check("a_halt_at4",   32'(halted), 32'd1);
      check("a_mem5",       32'(dut.u_mem.mem[5]), 32'h07);
      check("a_acc",        32'(dut.acc), 32'h07);
      check("a_busy",       32'(busy), 32'd0);

      // Borrow skip, plus a load attempt while busy.
      load(5, 3); load(1, 6); load(6, 1); load(2, 14); load(3, 15); load(14, 8'h40);
      ov_base = ov_cnt;
      pulse_start();
      tick(); tick();
      load(14, 8'h55);
      wait_halt("b_halt", 40);
      check("b_mem5",  32'(dut.u_mem.mem[5]),  32'h03);
      check("b_mem6",  32'(dut.u_mem.mem[6]),  32'hFE);
      check("b_mem14", 32'(dut.u_mem.mem[14]), 32'h40);
      check("b_acc",   32'(dut.acc), 32'hFE);
      check("b_pc",    32'(dut.pc),  32'd3);
      check("b_no_ov", 32'(ov_cnt - ov_base), 32'd0);
`ifdef RSSB_CYCCNT_EN
      check("b_cnt_halt", 32'(instr_cnt), 32'd2);
      load(6, 1);
      pulse_start();
      check("b_cnt_clr", 32'(instr_cnt), 32'd0);
      wait_halt("b_halt2", 40);
      check("b_cnt_halt2", 32'(instr_cnt), 32'd2);
`endif

      // Output write: 0 - 9 = 0xF7 with borrow, word 2 skipped.
      load(5, 9); load(1, 14); load(14, 0); load(2, 4); load(4, 8'h33); load(3, 15);
      ov_base = ov_cnt;
      pulse_start();
      wait_halt("c_halt", 40);
      check("c_ov_once",  32'(ov_cnt - ov_base), 32'd1);
      check("c_out_data", 32'(out_data), 32'hF7);
      check("c_mem14",    32'(dut.u_mem.mem[14]), 32'hF7);
      check("c_mem4",     32'(dut.u_mem.mem[4]),  32'h33);

      // Start pulse while busy must not restart the program.
      load(5, 7); load(1, 15);
      pulse_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("d_halt_early", 32'(halted), 32'd0);
      tick();
      check("d_halt_at4",   32'(halted), 32'd1);
      check("d_acc",        32'(dut.acc), 32'h07);

      // Load and start together in HALT: load wins, no run.
      load_en = 1'b1; start = 1'b1; load_addr = 4'd9; load_data = 8'h21;
      tick();
      load_en = 1'b0; start = 1'b0;
      check("e_busy",   32'(busy), 32'd0);
      check("e_halted", 32'(halted), 32'd1);
      check("e_mem9",   32'(dut.u_mem.mem[9]), 32'h21);

      // Asynchronous reset during the EXEC that would write the output word.
      load(5, 9); load(1, 14); load(14, 0);
      pulse_start();
      repeat (5) tick();
      check("f_in_exec", 32'(dut.state), 32'(S_EXEC));
      #2 rst = 1'b0;
      #1;
      check("f_busy",      32'(busy),      32'd0);
      check("f_halted",    32'(halted),    32'd0);
      check("f_out_valid", 32'(out_valid), 32'd0);
      check("f_out_data",  32'(out_data),  32'd0);
      check("f_state",     32'(dut.state), 32'(S_IDLE));
      check("f_acc",       32'(dut.acc),   32'd0);
      tick();
      rst = 1'b1;
      tick();
      check("f_busy_rel",  32'(busy), 32'd0);
      check("f_mem14",     32'(dut.u_mem.mem[14]), 32'h00);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
